// File: rtl/uart_bus_responder_pkg.sv
// Shared definitions for the UART bus responder: default bit timing,
// counter width and the TX/RX state encodings.
package uart_bus_responder_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;
  localparam int unsigned CNT_W                = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // 0->1 transition between a synchronized value and its delayed copy
  function automatic logic rose(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  // 1->0 transition between a synchronized value and its delayed copy
  function automatic logic fell(input logic cur, input logic prev);
    return ~cur & prev;
  endfunction

endpackage

// File: rtl/uart_bus_responder_if.sv
// Memory-controller side of the UART: read/write strobes and status flags.
interface uart_bus_responder_if;

  logic rdn;
  logic wrn;
  logic tbre;
  logic tsre;
  logic data_ready;
  logic framing_err;
  logic overrun_err;

  modport master (
    output rdn, wrn,
    input  tbre, tsre, data_ready, framing_err, overrun_err
  );

  modport slave (
    input  rdn, wrn,
    output tbre, tsre, data_ready, framing_err, overrun_err
  );

endinterface

// File: rtl/uart_bus_responder_rx_core.sv
// UART receiver: rxd synchronizer, start-bit glitch rejection, mid-bit
// sampling of 8 data bits (LSB first) and the stop bit. Completion is
// reported as single-cycle strobes; the holding register lives upstream.
module uart_rx_core
  import uart_bus_responder_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic [7:0] o_byte
);

  localparam cnt_t BIT_LAST  = cnt_t'(CLKS_PER_BIT - 1);
  localparam cnt_t HALF_LAST = cnt_t'(CLKS_PER_BIT / 2 - 1);

  logic       r_rxd_s1;
  logic       r_rxd_s2;
  logic       r_rxd_d;
  rx_state_t  r_state;
  rx_state_t  w_next;
  cnt_t       r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic       w_fall;
  logic       w_cnt_clr;
  logic       w_shift_en;
  logic       w_valid;
  logic       w_ferr;

  assign w_fall       = fell(r_rxd_s2, r_rxd_d);
  assign o_byte_valid = w_valid;
  assign o_frame_err  = w_ferr;
  assign o_byte       = r_shift;

  // Two-flop synchronizer plus delayed copy for edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
      r_rxd_d  <= 1'b1;
    end else begin
      r_rxd_s1 <= i_rxd;
      r_rxd_s2 <= r_rxd_s1;
      r_rxd_d  <= r_rxd_s2;
    end
  end

  // Next-state and sampling decisions
  always_comb begin
    w_next     = r_state;
    w_cnt_clr  = 1'b0;
    w_shift_en = 1'b0;
    w_valid    = 1'b0;
    w_ferr     = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_clr = 1'b1;
        if (w_fall) w_next = RX_START;
      end
      RX_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_clr = 1'b1;
          w_next    = r_rxd_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit == 3'd7) w_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_clr = 1'b1;
          w_valid   = r_rxd_s2;
          w_ferr    = ~r_rxd_s2;
          w_next    = RX_IDLE;
        end
      end
      default: begin
        w_cnt_clr = 1'b1;
        w_next    = RX_IDLE;
      end
    endcase
  end

  // State, bit-timing counter, bit index and shift register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      if (r_state != RX_DATA) r_bit <= '0;
      else if (w_shift_en)    r_bit <= r_bit + 1'b1;
      if (w_shift_en) r_shift <= {r_rxd_s2, r_shift[7:1]};
    end
  end

endmodule

// File: rtl/uart_bus_responder.sv
// UART bus responder: memory-mapped byte UART. Writes load the TX holding
// register, reads return the RX holding register on a tri-stated bus.
module uart_bus_responder
  import uart_bus_responder_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  uart_bus_responder_if.slave  bus,
  inout  wire  [7:0]           io_bus_data,
  output logic                 o_txd,
  input  logic                 i_rxd
);

  localparam cnt_t BIT_LAST = cnt_t'(CLKS_PER_BIT - 1);

  logic       r_rdn_s1;
  logic       r_rdn_s2;
  logic       r_rdn_d;
  logic       r_wrn_s1;
  logic       r_wrn_s2;
  logic       r_wrn_d;
  logic       w_rd_rise;
  logic       w_wr_accept;

  tx_state_t  r_tx_state;
  tx_state_t  w_tx_next;
  cnt_t       r_tx_cnt;
  logic [2:0] r_tx_bit;
  logic [7:0] r_tx_shift;
  logic [7:0] r_tx_hold;
  logic       r_tbre;
  logic       r_tsre;
  logic       w_tx_tick;
  logic       w_tx_load;
  logic       w_tx_shift;
  logic       w_tx_done;

  logic [7:0] r_rx_hold;
  logic       r_data_ready;
  logic       r_framing_err;
  logic       r_overrun_err;
  logic       w_rx_valid;
  logic       w_rx_ferr;
  logic [7:0] w_rx_byte;

  assign w_rd_rise   = rose(r_rdn_s2, r_rdn_d);
  assign w_wr_accept = rose(r_wrn_s2, r_wrn_d) & r_tbre;
  assign w_tx_tick   = (r_tx_cnt == BIT_LAST);

  assign io_bus_data     = r_rdn_s2 ? 'z : r_rx_hold;
  assign bus.tbre        = r_tbre;
  assign bus.tsre        = r_tsre;
  assign bus.data_ready  = r_data_ready;
  assign bus.framing_err = r_framing_err;
  assign bus.overrun_err = r_overrun_err;

  // Strobe synchronizers with delayed copies for edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdn_s1 <= 1'b1;
      r_rdn_s2 <= 1'b1;
      r_rdn_d  <= 1'b1;
      r_wrn_s1 <= 1'b1;
      r_wrn_s2 <= 1'b1;
      r_wrn_d  <= 1'b1;
    end else begin
      r_rdn_s1 <= bus.rdn;
      r_rdn_s2 <= r_rdn_s1;
      r_rdn_d  <= r_rdn_s2;
      r_wrn_s1 <= bus.wrn;
      r_wrn_s2 <= r_wrn_s1;
      r_wrn_d  <= r_wrn_s2;
    end
  end

  // TX next-state; a byte waiting at the end of the stop bit goes straight
  // to a new start bit so consecutive frames have no idle gap
  always_comb begin
    w_tx_next  = r_tx_state;
    w_tx_load  = 1'b0;
    w_tx_shift = 1'b0;
    w_tx_done  = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (!r_tbre) begin
          w_tx_load = 1'b1;
          w_tx_next = TX_START;
        end
      end
      TX_START: begin
        if (w_tx_tick) w_tx_next = TX_DATA;
      end
      TX_DATA: begin
        if (w_tx_tick) begin
          w_tx_shift = 1'b1;
          if (r_tx_bit == 3'd7) w_tx_next = TX_STOP;
        end
      end
      TX_STOP: begin
        if (w_tx_tick) begin
          if (!r_tbre) begin
            w_tx_load = 1'b1;
            w_tx_next = TX_START;
          end else begin
            w_tx_done = 1'b1;
            w_tx_next = TX_IDLE;
          end
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // TX state, timing, shift/holding registers and empty flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_hold  <= '0;
      r_tbre     <= 1'b1;
      r_tsre     <= 1'b1;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_cnt   <= (r_tx_state == TX_IDLE || w_tx_tick) ? '0 : r_tx_cnt + 1'b1;
      if (w_tx_load)       r_tx_bit <= '0;
      else if (w_tx_shift) r_tx_bit <= r_tx_bit + 1'b1;
      if (w_tx_load)       r_tx_shift <= r_tx_hold;
      else if (w_tx_shift) r_tx_shift <= {1'b0, r_tx_shift[7:1]};
      if (w_wr_accept) r_tx_hold <= io_bus_data;
      if (w_tx_load)        r_tbre <= 1'b1;
      else if (w_wr_accept) r_tbre <= 1'b0;
      if (w_tx_load)      r_tsre <= 1'b0;
      else if (w_tx_done) r_tsre <= 1'b1;
    end
  end

  // Serial output decoded from state so reset forces the line idle at once
  always_comb begin
    o_txd = 1'b1;
    case (r_tx_state)
      TX_START: o_txd = 1'b0;
      TX_DATA:  o_txd = r_tx_shift[0];
      default:  o_txd = 1'b1;
    endcase
  end

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rxd        (i_rxd),
    .o_byte_valid (w_rx_valid),
    .o_frame_err  (w_rx_ferr),
    .o_byte       (w_rx_byte)
  );

  // RX holding register and sticky flags; a completing byte beats a
  // coincident read acknowledge so the new byte is never lost
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_hold     <= '0;
      r_data_ready  <= 1'b0;
      r_framing_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_rx_valid) r_rx_hold <= w_rx_byte;
      if (w_rx_valid)     r_data_ready <= 1'b1;
      else if (w_rd_rise) r_data_ready <= 1'b0;
      if (w_rd_rise)                      r_overrun_err <= 1'b0;
      else if (w_rx_valid && r_data_ready) r_overrun_err <= 1'b1;
      if (w_rx_ferr)      r_framing_err <= 1'b1;
      else if (w_rd_rise) r_framing_err <= 1'b0;
    end
  end

endmodule
